// File: rtl/cpu_exec_ctrl_if.sv
// Bus bundle between the execution controller and its environment.
// The environment offers instructions and runs the ALU.
// The controller issues ALU work and reports status.
interface cpu_exec_ctrl_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        alu_start;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_done;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        retired;
    logic        illegal;
    logic        timeout;

    modport master (
        output instr_valid, instr, alu_result, alu_done, rd_addr,
        input  instr_ready, alu_start, alu_opcode, alu_a, alu_b,
               rd_data, busy, retired, illegal, timeout
    );

    modport slave (
        input  instr_valid, instr, alu_result, alu_done, rd_addr,
        output instr_ready, alu_start, alu_opcode, alu_a, alu_b,
               rd_data, busy, retired, illegal, timeout
    );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// Execution controller for a tiny four-register CPU.
// ALU ops go out through a start/done handshake with a watchdog.
// LOADI completes immediately, and illegal opcodes are flagged.
module cpu_exec_ctrl #(
    parameter int TIMEOUT = 64
) (
    input logic           clk,
    input logic           reset,
    cpu_exec_ctrl_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state;
    state_t next_state;

    logic signed [15:0] regs [4];
    logic [2:0]         op_q;
    logic [1:0]         rd_q;
    logic [15:0]        a_q;
    logic [15:0]        b_q;
    logic [CW-1:0]      cnt;
    logic               retired_q;
    logic               illegal_q;
    logic               timeout_q;

    logic        accept;
    logic        active;
    logic        expired;
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [10:0] imm;

    assign op  = bus.instr[15:13];
    assign rd  = bus.instr[12:11];
    assign rs1 = bus.instr[10:9];
    assign rs2 = bus.instr[8:7];
    assign imm = bus.instr[10:0];

    assign accept  = bus.instr_valid && (state == S_IDLE);
    assign active  = (state != S_IDLE);
    assign expired = (cnt == CNT_LAST);

    assign bus.instr_ready = (state == S_IDLE);
    assign bus.busy        = active;
    assign bus.alu_start   = (state == S_ISSUE);
    assign bus.alu_opcode  = active ? op_q : 3'd0;
    assign bus.alu_a       = active ? a_q  : 16'd0;
    assign bus.alu_b       = active ? b_q  : 16'd0;
    assign bus.rd_data     = regs[bus.rd_addr];
    assign bus.retired     = retired_q;
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;

    // State register; reset abandons any in-flight ALU operation.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic: only ALU opcodes leave IDLE; done beats expiry in WAIT.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept && !op[2]) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (bus.alu_done || expired) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, register writeback, watchdog count and status pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        rd_q <= rd;
                        a_q  <= regs[rs1];
                        b_q  <= regs[rs2];
                        if (op == 3'b100) begin
                            regs[rd]  <= {{5{imm[10]}}, imm};
                            retired_q <= 1'b1;
                        end else if (op[2]) begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (bus.alu_done) begin
                        regs[rd_q] <= bus.alu_result;
                        retired_q  <= 1'b1;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cpu_exec_ctrl.md
CPU_EXEC_CTRL -- requirements
Module: cpu_exec_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning maximum WAIT-state cycles allowed before the ALU operation is abandoned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr  input  16  instruction word: op[15:13], rd[12:11], rs1[10:9], rs2[8:7]; LOADI uses imm[10:0].
REQ-006 instr_ready  output  1  controller can accept an instruction this cycle.
REQ-007 alu_start  output  1  one-cycle ALU start pulse.
REQ-008 alu_opcode  output  3  ALU operation (000 add, 001 sub, 010 mul, 011 div).
REQ-009 alu_a, alu_b  output  16 each  signed ALU operands.
REQ-010 alu_result  input  16  signed ALU result, valid when alu_done=1.
REQ-011 alu_done  input  1  ALU completion pulse.
REQ-012 rd_addr  input  2  debug register read address.
REQ-013 rd_data  output  16  combinational read of register rd_addr.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 retired, illegal, timeout  output  1 each  one-cycle status pulses.

Function
REQ-016 Internal register file: 4 x 16-bit signed, r0..r3, all writable.
REQ-017 States: IDLE, ISSUE, WAIT; instr_ready=1 only in IDLE.
REQ-018 Accept = instr_valid & instr_ready at a rising edge; fields and operands r[rs1], r[rs2] latched on that edge.
REQ-019 op 000-011: IDLE->ISSUE; in ISSUE alu_start=1 for exactly one cycle, then ->WAIT.
REQ-020 alu_opcode, alu_a, alu_b hold latched values from ISSUE until WAIT exits; 0 otherwise.
REQ-021 WAIT: on alu_done=1, r[rd] <= alu_result at that edge, retired pulses next cycle, ->IDLE.
REQ-022 WAIT cycle counter starts at 0 on entry, increments each WAIT cycle without alu_done.
REQ-023 Counter reaches TIMEOUT-1 without alu_done: no writeback, timeout pulses next cycle, ->IDLE.
REQ-024 alu_done and timeout condition in the same cycle: alu_done wins (writeback, retired, no timeout).
REQ-025 op 100 (LOADI): r[rd] <= sign-extended imm[10:0] on the accept edge, retired pulses next cycle, stays IDLE, no ALU activity.
REQ-026 op 101-111: instruction consumed, no writeback, illegal pulses next cycle, stays IDLE.
REQ-027 alu_done outside WAIT is ignored.
REQ-028 rs1/rs2 equal to rd is legal; operands are the pre-write values.
REQ-029 Minimum ALU instruction latency: accept edge to writeback edge = 2 cycles plus ALU latency; next instruction accepted the cycle after returning to IDLE.

Reset
REQ-030 reset=0 at a rising edge: state IDLE, r0..r3=0, counter=0, alu_start=0, alu_opcode/a/b=0, retired/illegal/timeout=0, busy=0.
REQ-031 reset takes priority in any state, including mid-WAIT; the pending operation is abandoned without writeback, and a later alu_done is ignored.
REQ-032 instr_ready=1 on the first cycle after reset is released.

Verification
REQ-033 LOADI r1=5, LOADI r2=-3 (imm 0x7FD), ADD r3,r1,r2; ALU model done 1 cycle after start with 2 -> alu_a=0x0005, alu_b=0xFFFD, r3=0x0002, retired pulses once per instruction.
REQ-034 MUL r0,r1,r1, ALU done 20 cycles after start with 25 -> alu_start high exactly 1 cycle, busy high throughout, r0=25, operands stable whole WAIT.
REQ-035 DIV issued, alu_done never asserted, TIMEOUT=64 -> timeout pulse after the 64th WAIT cycle, rd unchanged, instr_ready=1 afterwards.
REQ-036 instr op=110 -> illegal pulse, no alu_start, registers unchanged; stray alu_done in IDLE -> no effect.
REQ-037 reset=0 during WAIT of a SUB, then alu_done returned after release -> all registers 0, no writeback, no retired.
REQ-038 alu_done in the same cycle the counter reaches TIMEOUT-1 -> writeback and retired, no timeout pulse.
